display_scheduler: RTL

Arbitrates and sequences the 4-digit BCD seven-segment scanner between three data sources. Generates the reduced-rate scan strobe from the system clock and rotates display ownership round-robin with a programmable dwell time. Provides an alert override, frame-aligned (tear-free) data updates, leading-zero blanking, and a BCD-validity flag. Sits between the application sources and the segment scan/drive logic.

---
 rtl/display_scheduler_if.sv | 25 ++
 rtl/display_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler_if.sv
// Bundle between the application sources and the display scheduler.
// The master drives requests and BCD data; the slave returns the scan strobe and frame data.
interface display_scheduler_if;
    logic [2:0]  req;
    logic [15:0] bcd_ch0;
    logic [15:0] bcd_ch1;
    logic [15:0] bcd_ch2;
    logic        alert;
    logic        hold;
    logic        scan_tick;
    logic [15:0] bcd_out;
    logic [3:0]  blank_mask;
    logic [2:0]  grant;
    logic        bcd_err;

    modport master (
        output req, bcd_ch0, bcd_ch1, bcd_ch2, alert, hold,
        input  scan_tick, bcd_out, blank_mask, grant, bcd_err
    );

    modport slave (
        input  req, bcd_ch0, bcd_ch1, bcd_ch2, alert, hold,
        output scan_tick, bcd_out, blank_mask, grant, bcd_err
    );
endinterface

// File: rtl/display_scheduler.sv
// Round-robin owner of the 4-digit BCD scanner with alert override and frame-aligned latching.
// Generates the scan strobe, rotates ownership every DWELL_TICKS strobes, latches data every 4 strobes.
module display_scheduler #(
    parameter int SCAN_DIV    = 50000,
    parameter int DWELL_TICKS = 2000
) (
    input  logic             clk,
    input  logic             rst_n,
    display_scheduler_if.slave bus
);
    localparam int DATA_W  = 16;
    localparam int CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DWELL_W = $clog2(DWELL_TICKS + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        ALERT = 2'd2
    } state_t;

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic               tick;
    logic [1:0]         frame;
    logic               frame_bnd;

    state_t             state, state_nx;
    logic [1:0]         cur, cur_nx;
    logic               saved_vld, saved_vld_nx;
    logic [1:0]         saved, saved_nx;
    logic [DWELL_W-1:0] dwell, dwell_nx;
    logic [2:0]         grant_nx;
    logic [2:0]         grant_r;

    logic [2:0]         pick_cur;
    logic [2:0]         pick_lowest;
    logic [2:0]         pick_exit;

    logic [DATA_W-1:0]  sel;
    logic [DATA_W-1:0]  bcd_out_r;
    logic [3:0]         blank_r;
    logic               err_r;

    // Next requesting channel after 'from' in 0->1->2->0 order, 'from' itself last.
    // Result is {found, index}.
    function automatic logic [2:0] pick_after(input logic [1:0] from, input logic [2:0] r);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = (from == 2'd2) ? 2'd0 : from + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        if (r[c1])
            return {1'b1, c1};
        if (r[c2])
            return {1'b1, c2};
        if (r[from])
            return {1'b1, from};
        return 3'b000;
    endfunction

    function automatic logic [3:0] lead_blank(input logic [DATA_W-1:0] v);
        logic [3:0] m;
        m[3] = (v[15:12] == 4'd0);
        m[2] = m[3] & (v[11:8] == 4'd0);
        m[1] = m[2] & (v[7:4] == 4'd0);
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic logic has_bad_digit(input logic [DATA_W-1:0] v);
        return (v[15:12] > 4'd9) | (v[11:8] > 4'd9) | (v[7:4] > 4'd9) | (v[3:0] > 4'd9);
    endfunction

    // Prescaler: tick is registered from the next count so it is high exactly while cnt == SCAN_DIV-1.
    assign cnt_nx = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            tick  <= 1'b0;
            frame <= 2'd0;
        end else begin
            cnt  <= cnt_nx;
            tick <= (cnt_nx == CNT_LAST);
            if (tick)
                frame <= frame + 2'd1;
        end
    end

    assign frame_bnd = tick & (frame == 2'd3);

    assign pick_cur    = pick_after(cur, bus.req);
    assign pick_lowest = pick_after(2'd2, bus.req);

    always_comb begin
        pick_exit = pick_lowest;
        if (saved_vld) begin
            if (bus.req[saved])
                pick_exit = {1'b1, saved};
            else
                pick_exit = pick_after(saved, bus.req);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= 2'd0;
            saved_vld <= 1'b0;
            saved     <= 2'd0;
            dwell     <= '0;
            grant_r   <= 3'b000;
        end else begin
            state     <= state_nx;
            cur       <= cur_nx;
            saved_vld <= saved_vld_nx;
            saved     <= saved_nx;
            dwell     <= dwell_nx;
            grant_r   <= grant_nx;
        end
    end

    // Priority: alert, then loss of the current request, then dwell expiry.
    always_comb begin
        state_nx     = state;
        cur_nx       = cur;
        saved_vld_nx = saved_vld;
        saved_nx     = saved;
        dwell_nx     = dwell;
        case (state)
            IDLE: begin
                if (bus.alert) begin
                    state_nx     = ALERT;
                    saved_vld_nx = 1'b0;
                end else if (pick_lowest[2]) begin
                    state_nx = SHOW;
                    cur_nx   = pick_lowest[1:0];
                    dwell_nx = '0;
                end
            end
            SHOW: begin
                if (bus.alert) begin
                    state_nx     = ALERT;
                    saved_vld_nx = 1'b1;
                    saved_nx     = cur;
                end else if (!bus.req[cur]) begin
                    dwell_nx = '0;
                    if (pick_cur[2])
                        cur_nx = pick_cur[1:0];
                    else
                        state_nx = IDLE;
                end else if (tick && !bus.hold) begin
                    if (dwell == DWELL_LAST) begin
                        cur_nx   = pick_cur[1:0];
                        dwell_nx = '0;
                    end else begin
                        dwell_nx = dwell + 1'b1;
                    end
                end
            end
            ALERT: begin
                if (!bus.alert) begin
                    dwell_nx = '0;
                    if (pick_exit[2]) begin
                        state_nx = SHOW;
                        cur_nx   = pick_exit[1:0];
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        grant_nx = 3'b000;
        if (state_nx == SHOW)
            grant_nx = 3'b001 << cur_nx;
        else if (state_nx == ALERT)
            grant_nx = 3'b100;
    end

    always_comb begin
        sel = bus.bcd_ch2;
        if (state == SHOW) begin
            case (cur)
                2'd0:    sel = bus.bcd_ch0;
                2'd1:    sel = bus.bcd_ch1;
                default: sel = bus.bcd_ch2;
            endcase
        end
    end

    // Frame boundary: sample the owner's data once per 4 strobes so a frame never mixes channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_out_r <= '0;
            blank_r   <= 4'hF;
            err_r     <= 1'b0;
        end else if (frame_bnd) begin
            if (state == IDLE) begin
                bcd_out_r <= '0;
                blank_r   <= 4'hF;
                err_r     <= 1'b0;
            end else begin
                bcd_out_r <= sel;
                blank_r   <= lead_blank(sel);
                err_r     <= has_bad_digit(sel);
            end
        end
    end

    assign bus.scan_tick  = tick;
    assign bus.grant      = grant_r;
    assign bus.bcd_out    = bcd_out_r;
    assign bus.blank_mask = blank_r;
    assign bus.bcd_err    = err_r;
endmodule
